// File: rtl/seq_pkg.sv
// Shared types and limits for the tap sequencer.
// MAX_NTAPS is the largest tap count the sequencer is built to handle.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  localparam int MAX_NTAPS = 256;

endpackage

// File: rtl/tap_sequencer_counter.sv
// Modulo-N tap counter.
// The counter wraps explicitly at N-1, so it never holds codes >= N when N is not a power of 2.
module tap_counter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last = (r_count == W'(N - 1));
  assign count  = r_count;
  assign last   = w_last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_last ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/tap_sequencer.sv
// Control sequencer for the multiply-accumulate datapath: one sample per handshake,
// NTAPS accumulate cycles, then the result is held until downstream takes it.
module tap_sequencer
  import seq_pkg::*;
#(
  parameter  int NTAPS      = 4,
  parameter  int CONTINUOUS = 0,
  localparam int SEL_W      = $clog2(NTAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_sample,
  output logic [SEL_W-1:0] mux_sel,
  output logic             clear_accum,
  output logic             accum_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output seq_state_t       dbg_state
);

  // Handshakes: a sample moves when in_valid & in_ready are both high on a rising
  // edge; a result moves when out_valid & out_ready are both high on a rising edge.
  // out_valid never drops before out_ready has been sampled high.

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [SEL_W-1:0] w_tap;
  logic             w_tap_last;
  logic             w_tap_inc;
  logic             w_accept;

  tap_counter #(
    .N (NTAPS)
  ) u_tap_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_tap_inc),
    .clr   (w_accept),
    .count (w_tap),
    .last  (w_tap_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = IDLE;
    in_ready     = 1'b0;
    load_sample  = 1'b0;
    clear_accum  = 1'b0;
    accum_en     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    w_tap_inc    = 1'b0;
    w_accept     = 1'b0;

    case (r_state)
      IDLE: begin
        busy         = 1'b0;
        in_ready     = 1'b1;
        w_accept     = in_valid;
        load_sample  = in_valid;
        w_next_state = in_valid ? MAC : IDLE;
      end
      MAC: begin
        accum_en     = enable;
        clear_accum  = enable && (w_tap == '0);
        w_tap_inc    = enable;
        w_next_state = (enable && w_tap_last) ? HOLD : MAC;
      end
      HOLD: begin
        out_valid    = 1'b1;
        w_next_state = HOLD;
        if (CONTINUOUS != 0) begin
          // Back-to-back mode: the result leaving frees the slot for the next sample.
          in_ready    = out_ready;
          w_accept    = out_ready && in_valid;
          load_sample = out_ready && in_valid;
        end
        if (out_ready) begin
          w_next_state = ((CONTINUOUS != 0) && in_valid) ? MAC : IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign mux_sel   = w_tap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench for tap_sequencer: three instances (NTAPS=4, NTAPS=5, NTAPS=4 continuous)
// driven one at a time from a single sequence of scenario tasks.
module tb_tap_sequencer;
  import seq_pkg::*;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  // Instance 0: NTAPS=4, CONTINUOUS=0
  logic       in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic       in_ready0, ld0, clr0, aen0, ov0, busy0;
  logic [1:0] sel0;
  seq_state_t st0;
  // Instance 1: NTAPS=5, CONTINUOUS=0
  logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic       in_ready1, ld1, clr1, aen1, ov1, busy1;
  logic [2:0] sel1;
  seq_state_t st1;
  // Instance 2: NTAPS=4, CONTINUOUS=1
  logic       in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic       in_ready2, ld2, clr2, aen2, ov2, busy2;
  logic [1:0] sel2;
  seq_state_t st2;

  tap_sequencer #(.NTAPS(4), .CONTINUOUS(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid0), .in_ready(in_ready0),
    .load_sample(ld0), .mux_sel(sel0), .clear_accum(clr0), .accum_en(aen0),
    .out_valid(ov0), .out_ready(out_ready0), .busy(busy0), .dbg_state(st0)
  );
  tap_sequencer #(.NTAPS(5), .CONTINUOUS(0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid1), .in_ready(in_ready1),
    .load_sample(ld1), .mux_sel(sel1), .clear_accum(clr1), .accum_en(aen1),
    .out_valid(ov1), .out_ready(out_ready1), .busy(busy1), .dbg_state(st1)
  );
  tap_sequencer #(.NTAPS(4), .CONTINUOUS(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid2), .in_ready(in_ready2),
    .load_sample(ld2), .mux_sel(sel2), .clear_accum(clr2), .accum_en(aen2),
    .out_valid(ov2), .out_ready(out_ready2), .busy(busy2), .dbg_state(st2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Flag vectors below are {load_sample, in_ready, clear_accum, accum_en, out_valid, busy}.

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({ld0, in_ready0, clr0, aen0, ov0, busy0} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_flags0 got=%b exp=010000", {ld0, in_ready0, clr0, aen0, ov0, busy0});
    end
    checks++;
    if (sel0 !== 2'd0 || st0 !== IDLE) begin
      errors++;
      $display("FAIL reset_sel_state0 got sel=%0d st=%0d exp sel=0 st=0", sel0, st0);
    end
    checks++;
    if ({ld1, in_ready1, clr1, aen1, ov1, busy1, sel1} !== 9'b010000_000) begin
      errors++;
      $display("FAIL reset_dut1 got=%b exp=010000000", {ld1, in_ready1, clr1, aen1, ov1, busy1, sel1});
    end
    checks++;
    if ({ld2, in_ready2, clr2, aen2, ov2, busy2, sel2} !== 8'b010000_00) begin
      errors++;
      $display("FAIL reset_dut2 got=%b exp=01000000", {ld2, in_ready2, clr2, aen2, ov2, busy2, sel2});
    end
    next_cycle();
  endtask

  task automatic test_single_sample();
    logic [5:0] exp_f[7] = '{6'b110000, 6'b001101, 6'b000101, 6'b000101, 6'b000101, 6'b000011, 6'b010000};
    logic [1:0] exp_s[7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    enable = 1'b1;
    out_ready0 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid0 = (c == 0);
      #1;
      checks++;
      if ({ld0, in_ready0, clr0, aen0, ov0, busy0} !== exp_f[c] || sel0 !== exp_s[c]) begin
        errors++;
        $display("FAIL single_c%0d got flags=%b sel=%0d exp flags=%b sel=%0d",
                 c, {ld0, in_ready0, clr0, aen0, ov0, busy0}, sel0, exp_f[c], exp_s[c]);
      end
      next_cycle();
    end
    in_valid0 = 1'b0;
  endtask

  task automatic test_odd_depth();
    logic [5:0] exp_f;
    logic [2:0] exp_s;
    enable = 1'b1;
    out_ready1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid1 = (c == 0);
      exp_s = (c >= 1 && c <= 5) ? 3'(c - 1) : 3'd0;
      case (c)
        0:       exp_f = 6'b110000;
        1:       exp_f = 6'b001101;
        2, 3, 4, 5: exp_f = 6'b000101;
        6:       exp_f = 6'b000011;
        default: exp_f = 6'b010000;
      endcase
      #1;
      checks++;
      if ({ld1, in_ready1, clr1, aen1, ov1, busy1} !== exp_f || sel1 !== exp_s) begin
        errors++;
        $display("FAIL odd_c%0d got flags=%b sel=%0d exp flags=%b sel=%0d",
                 c, {ld1, in_ready1, clr1, aen1, ov1, busy1}, sel1, exp_f, exp_s);
      end
      checks++;
      if (sel1 > 3'd4) begin
        errors++;
        $display("FAIL odd_range_c%0d got sel=%0d exp <=4", c, sel1);
      end
      next_cycle();
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_stall_backpressure();
    logic [5:0] exp_f[13] = '{6'b110000, 6'b001101, 6'b000101, 6'b000001, 6'b000001, 6'b000101,
                              6'b000101, 6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b000011,
                              6'b010000};
    logic [1:0] exp_s[13] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3,
                              2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 13; c++) begin
      enable     = !(c == 3 || c == 4);
      in_valid0  = (c == 0) || (c >= 7 && c <= 10);
      out_ready0 = !(c >= 7 && c <= 10);
      #1;
      checks++;
      if ({ld0, in_ready0, clr0, aen0, ov0, busy0} !== exp_f[c] || sel0 !== exp_s[c]) begin
        errors++;
        $display("FAIL stall_c%0d got flags=%b sel=%0d exp flags=%b sel=%0d",
                 c, {ld0, in_ready0, clr0, aen0, ov0, busy0}, sel0, exp_f[c], exp_s[c]);
      end
      next_cycle();
    end
    enable = 1'b1;
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_f;
    logic [1:0] exp_s;
    int m;
    enable = 1'b1;
    for (int c = 0; c < 23; c++) begin
      in_valid2  = (c < 16);
      out_ready2 = (c != 20);
      m = c % 5;
      exp_s = (m >= 1 && m <= 4 && c < 20) ? 2'(m - 1) : 2'd0;
      if (c < 20) begin
        exp_f = {m == 0 && c < 16, m == 0 && c < 16, m == 1, m != 0, m == 0 && c > 0, c > 0};
      end else if (c == 20) begin
        exp_f = 6'b000011;
      end else if (c == 21) begin
        exp_f = 6'b010011;
      end else begin
        exp_f = 6'b010000;
      end
      #1;
      checks++;
      if ({ld2, in_ready2, clr2, aen2, ov2, busy2} !== exp_f || sel2 !== exp_s) begin
        errors++;
        $display("FAIL b2b_c%0d got flags=%b sel=%0d exp flags=%b sel=%0d",
                 c, {ld2, in_ready2, clr2, aen2, ov2, busy2}, sel2, exp_f, exp_s);
      end
      next_cycle();
    end
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    enable = 1'b1;
    out_ready0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid0 = (c == 0);
      #1;
      if (c == 3) begin
        checks++;
        if (sel0 !== 2'd2 || st0 !== MAC) begin
          errors++;
          $display("FAIL midmac_pre got sel=%0d st=%0d exp sel=2 st=1", sel0, st0);
        end
        reset = 1'b1;
      end
      next_cycle();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (st0 !== IDLE || sel0 !== 2'd0 || {ld0, in_ready0, clr0, aen0, ov0, busy0} !== 6'b010000) begin
      errors++;
      $display("FAIL midmac_after got st=%0d sel=%0d flags=%b exp st=0 sel=0 flags=010000",
               st0, sel0, {ld0, in_ready0, clr0, aen0, ov0, busy0});
    end
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      checks++;
      if (ov0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL midmac_quiet_c%0d got ov=%b busy=%b exp ov=0 busy=0", c, ov0, busy0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_odd_depth();
    test_stall_backpressure();
    test_back_to_back();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
